// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU/MDU: opcodes, FSM states, clog2 helper.
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_SLL   = 4'b0010;
    localparam logic [3:0] ALU_SLT   = 4'b0011;
    localparam logic [3:0] ALU_SLTU  = 4'b0100;
    localparam logic [3:0] ALU_XOR   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_OR    = 4'b1000;
    localparam logic [3:0] ALU_AND   = 4'b1001;
    localparam logic [3:0] ALU_MUL   = 4'b1010;
    localparam logic [3:0] ALU_MULHU = 4'b1011;
    localparam logic [3:0] ALU_DIVU  = 4'b1100;
    localparam logic [3:0] ALU_REMU  = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Smallest r with 2**r >= v.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((33'd1 << i) < 33'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative engine shared by multiply (shift-add) and divide (restoring).
// The divide path exists only when ALU_SEQ_DIV_EN is defined.
module alu_seq_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 is_div,
    input  logic [WIDTH-1:0]     opa,
    input  logic [WIDTH-1:0]     opb,
    output logic                 busy,
    output logic                 done_c,
    output logic [2*WIDTH-1:0]   prod_nxt_c
);

    localparam int unsigned CW = clog2(WIDTH) + 1;

    // prod_q: {hi, lo} = {product hi, multiplier} for mul, {remainder, quotient} for div.
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   aux_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH:0]     sum_c;

`ifdef ALU_SEQ_DIV_EN
    logic               div_q;
    logic [WIDTH:0]     diff_c;
`else
    logic               unused_is_div;
    assign unused_is_div = is_div;
`endif

    assign busy   = (cnt_q != '0);
    assign done_c = (cnt_q == CW'(1));

    // Value prod_q takes after the current iteration.
    always_comb begin
        sum_c      = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, aux_q};
        prod_nxt_c = prod_q[0] ? {sum_c, prod_q[WIDTH-1:1]} : {1'b0, prod_q[2*WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
        diff_c = prod_q[2*WIDTH-1:WIDTH-1] - {1'b0, aux_q};
        if (div_q) begin
            prod_nxt_c = diff_c[WIDTH] ? {prod_q[2*WIDTH-2:0], 1'b0}
                                       : {diff_c[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
        end
`endif
    end

    // Load on start, then one iteration per cycle until the counter empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            aux_q  <= '0;
            cnt_q  <= '0;
`ifdef ALU_SEQ_DIV_EN
            div_q  <= 1'b0;
`endif
        end else if (start) begin
            prod_q <= {{WIDTH{1'b0}}, opa};
            aux_q  <= opb;
            cnt_q  <= CW'(WIDTH);
`ifdef ALU_SEQ_DIV_EN
            div_q  <= is_div;
`endif
        end else if (busy) begin
            prod_q <= prod_nxt_c;
            cnt_q  <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq_mdu.sv
// Registered ALU with iterative unsigned MUL/MULHU/DIVU/REMU and valid/ready handshake.
// ALU_SEQ_DIV_EN: when defined, DIVU/REMU are implemented; otherwise they return 0.
module alu_seq_mdu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic [3:0]       ALUsel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUresult,
    output logic             div_zero
);

    localparam int unsigned SW = clog2(WIDTH);

    state_t             state_q, state_n;
    logic [WIDTH-1:0]   res_q, res_n;
    logic               dz_q, dz_n;
    logic [3:0]         op_q, op_n;
    logic               start_c;
    logic               accept_c;
    logic [WIDTH-1:0]   alu_res_c;
    logic               alu_dz_c;
    logic               is_iter_c;
    logic [SW-1:0]      shamt_c;
    logic               iter_busy;
    logic               iter_done_c;
    logic [2*WIDTH-1:0] iter_prod_c;

    assign out_valid = (state_q == ST_DONE);
    assign ALUresult = res_q;
    assign div_zero  = dz_q;

    alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_c),
        .is_div     ((ALUsel == ALU_DIVU) || (ALUsel == ALU_REMU)),
        .opa        (OperandA),
        .opb        (OperandB),
        .busy       (iter_busy),
        .done_c     (iter_done_c),
        .prod_nxt_c (iter_prod_c)
    );

    // Single-cycle results and iterative-op classification from the request inputs.
    always_comb begin
        alu_res_c = '0;
        alu_dz_c  = 1'b0;
        is_iter_c = 1'b0;
        shamt_c   = OperandB[SW-1:0];
        case (ALUsel)
            ALU_ADD:   alu_res_c = OperandA + OperandB;
            ALU_SUB:   alu_res_c = OperandA - OperandB;
            ALU_SLL:   alu_res_c = OperandA << shamt_c;
            ALU_SLT:   alu_res_c = WIDTH'($signed(OperandA) < $signed(OperandB));
            ALU_SLTU:  alu_res_c = WIDTH'(OperandA < OperandB);
            ALU_XOR:   alu_res_c = OperandA ^ OperandB;
            ALU_SRL:   alu_res_c = OperandA >> shamt_c;
            ALU_SRA:   alu_res_c = WIDTH'($signed(OperandA) >>> shamt_c);
            ALU_OR:    alu_res_c = OperandA | OperandB;
            ALU_AND:   alu_res_c = OperandA & OperandB;
            ALU_MUL,
            ALU_MULHU: is_iter_c = 1'b1;
`ifdef ALU_SEQ_DIV_EN
            ALU_DIVU: begin
                if (OperandB == '0) begin
                    alu_res_c = '1;
                    alu_dz_c  = 1'b1;
                end else begin
                    is_iter_c = 1'b1;
                end
            end
            ALU_REMU: begin
                if (OperandB == '0) begin
                    alu_res_c = OperandA;
                    alu_dz_c  = 1'b1;
                end else begin
                    is_iter_c = 1'b1;
                end
            end
`endif
            default:   alu_res_c = '0;
        endcase
    end

    // Handshake FSM next-state and result capture.
    always_comb begin
        state_n  = state_q;
        res_n    = res_q;
        dz_n     = dz_q;
        op_n     = op_q;
        start_c  = 1'b0;
        in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
        accept_c = in_valid && in_ready;
        case (state_q)
            ST_BUSY: begin
                if (iter_busy && iter_done_c) begin
                    state_n = ST_DONE;
                    dz_n    = 1'b0;
                    res_n   = ((op_q == ALU_MULHU) || (op_q == ALU_REMU))
                              ? iter_prod_c[2*WIDTH-1:WIDTH] : iter_prod_c[WIDTH-1:0];
                end
            end
            ST_DONE: begin
                if (out_ready) state_n = ST_IDLE;
            end
            default: ;
        endcase
        if (accept_c) begin
            op_n = ALUsel;
            if (is_iter_c) begin
                state_n = ST_BUSY;
                start_c = 1'b1;
            end else begin
                state_n = ST_DONE;
                res_n   = alu_res_c;
                dz_n    = alu_dz_c;
            end
        end
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
            dz_q    <= 1'b0;
            op_q    <= '0;
        end else begin
            state_q <= state_n;
            res_q   <= res_n;
            dz_q    <= dz_n;
            op_q    <= op_n;
        end
    end

endmodule

// File: tb/tb_alu_seq_mdu.sv
// Directed bench for alu_seq_mdu at WIDTH=32 and WIDTH=8.
module tb_alu_seq_mdu;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, dz;
    logic [31:0] opa, opb, res;
    logic [3:0]  alusel;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, dz8;
    logic [7:0]  a8, b8, res8;
    logic [3:0]  sel8;

    int n_chk;
    int n_fail;

`ifdef ALU_SEQ_DIV_EN
    localparam logic [31:0] E_DIVU  = 32'd14;
    localparam logic [31:0] E_REMU  = 32'd2;
    localparam logic [31:0] E_DIV0  = 32'hFFFF_FFFF;
    localparam logic [31:0] E_REM0  = 32'd123;
    localparam logic        E_DZ    = 1'b1;
    localparam int          L_DIV   = 33;
    localparam logic [7:0]  E_DIV8  = 8'd28;
    localparam logic [7:0]  E_REM8  = 8'd4;
    localparam int          L_DIV8  = 9;
`else
    localparam logic [31:0] E_DIVU  = 32'd0;
    localparam logic [31:0] E_REMU  = 32'd0;
    localparam logic [31:0] E_DIV0  = 32'd0;
    localparam logic [31:0] E_REM0  = 32'd0;
    localparam logic        E_DZ    = 1'b0;
    localparam int          L_DIV   = 1;
    localparam logic [7:0]  E_DIV8  = 8'd0;
    localparam logic [7:0]  E_REM8  = 8'd0;
    localparam int          L_DIV8  = 1;
`endif

    alu_seq_mdu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .OperandA  (opa),
        .OperandB  (opb),
        .ALUsel    (alusel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUresult (res),
        .div_zero  (dz)
    );

    alu_seq_mdu #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .OperandA  (a8),
        .OperandB  (b8),
        .ALUsel    (sel8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .ALUresult (res8),
        .div_zero  (dz8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request, scramble inputs while busy, measure latency, then consume.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input logic exp_dz,
                         input int exp_lat);
        int lat;
        chk({tag, "_rdy"}, 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        alusel   = op;
        opa      = a;
        opb      = b;
        @(posedge clk); #1;
        lat = 1;
        while (!out_valid && lat < 200) begin
            in_valid = 1'b1;
            alusel   = ALU_MUL;
            opa      = $urandom;
            opb      = $urandom;
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_res"}, 64'(res), 64'(exp));
        chk({tag, "_dz"}, 64'(dz), 64'(exp_dz));
        @(posedge clk); #1;
    endtask

    task automatic op8(input string tag, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] exp, input int exp_lat);
        int lat;
        in_valid8 = 1'b1;
        sel8      = op;
        a8        = a;
        b8        = b;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 1;
        while (!out_valid8 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_res"}, 64'(res8), 64'(exp));
        @(posedge clk); #1;
    endtask

    initial begin
        int seen;
        n_chk      = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        opa        = '0;
        opb        = '0;
        alusel     = '0;
        in_valid8  = 1'b0;
        out_ready8 = 1'b1;
        a8         = '0;
        b8         = '0;
        sel8       = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ov", 64'(out_valid), 64'(0));
        chk("rst_res", 64'(res), 64'(0));
        chk("rst_dz", 64'(dz), 64'(0));
        chk("rst_rdy", 64'(in_ready), 64'(1));
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("sub", ALU_SUB, 32'd8, 32'd1, 32'd7, 1'b0, 1);
        chk("sub_idle", 64'(out_valid), 64'(0));
        do_op("add_ovf", ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);
        do_op("mul", ALU_MUL, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 1'b0, 33);
        do_op("mulhu", ALU_MULHU, 32'h0001_0003, 32'h0002_0005, 32'h0000_0002, 1'b0, 33);
        do_op("mulhu_max", ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
        do_op("mul_max", ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33);
        do_op("divu", ALU_DIVU, 32'd100, 32'd7, E_DIVU, 1'b0, L_DIV);
        do_op("remu", ALU_REMU, 32'd100, 32'd7, E_REMU, 1'b0, L_DIV);
        do_op("divu0", ALU_DIVU, 32'd100, 32'd0, E_DIV0, E_DZ, 1);
        do_op("remu0", ALU_REMU, 32'd123, 32'd0, E_REM0, E_DZ, 1);
        do_op("sra", ALU_SRA, 32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 1'b0, 1);
        do_op("srl", ALU_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1);
        do_op("sll", ALU_SLL, 32'd1, 32'h0000_001F, 32'h8000_0000, 1'b0, 1);
        do_op("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1);
        do_op("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);
        do_op("or", ALU_OR, 32'hF000_000F, 32'h0F00_00F0, 32'hFF00_00FF, 1'b0, 1);
        do_op("and", ALU_AND, 32'hF0F0_1234, 32'hFF00_FFFF, 32'hF000_1234, 1'b0, 1);
        do_op("op_e", 4'b1110, 32'd5, 32'd6, 32'd0, 1'b0, 1);

        // Back-pressure: result held, in_ready low until out_ready rises.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        alusel    = ALU_ADD;
        opa       = 32'd5;
        opb       = 32'd6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_ov", 64'(out_valid), 64'(1));
            chk("bp_res", 64'(res), 64'(11));
            chk("bp_rdy", 64'(in_ready), 64'(0));
            @(posedge clk); #1;
        end
        in_valid  = 1'b1;
        alusel    = ALU_XOR;
        opa       = 32'hF0F0_F0F0;
        opb       = 32'h0FF0_0FF0;
        out_ready = 1'b1;
        #1;
        chk("bp_pass_rdy", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bb_xor_ov", 64'(out_valid), 64'(1));
        chk("bb_xor_res", 64'(res), 64'(32'hFF00_FF00));
        @(posedge clk); #1;
        chk("bb_idle", 64'(out_valid), 64'(0));

        // Reset in the middle of a multiply.
        in_valid = 1'b1;
        alusel   = ALU_MUL;
        opa      = 32'd1234;
        opb      = 32'd5678;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_ov", 64'(out_valid), 64'(0));
        chk("mrst_res", 64'(res), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mrst_rdy", 64'(in_ready), 64'(1));
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        chk("mrst_stale", 64'(seen), 64'(0));

        op8("w8_add", ALU_ADD, 8'hF0, 8'h20, 8'h10, 1);
        op8("w8_mul", ALU_MUL, 8'h13, 8'h0B, 8'hD1, 9);
        op8("w8_mulhu", ALU_MULHU, 8'hFF, 8'hFF, 8'hFE, 9);
        op8("w8_sra", ALU_SRA, 8'h80, 8'h09, 8'hC0, 1);
        op8("w8_divu", ALU_DIVU, 8'd200, 8'd7, E_DIV8, L_DIV8);
        op8("w8_remu", ALU_REMU, 8'd200, 8'd7, E_REM8, L_DIV8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
